future_round_controller: RTL and testbench
==========================================

# future_round_controller

Round sequencer for the iterative 64-bit FUTURE encryption datapath. It drives the 64-bit feedback mux select and the state-register enable. Each block takes one load cycle followed by ROUNDS feedback cycles. The controller publishes the current round index and last-round flag to the round-function logic, and holds the finished ciphertext under a valid/ack handshake.

## Interface
- ROUNDS, 10, number of round cycles per block (≥1)
- CW, 4, round counter width (2^CW > ROUNDS)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request to load a new block (datapath input = whitened plaintext)
- abort  in  1  synchronous cancel; returns to IDLE
- ready  out  1  start will be accepted this cycle
- sel  out  64  mux select, bitwise: all-zeros = input operand, all-ones = feedback operand
- state_en  out  1  state-register load enable
- round  out  CW  current round index, 0 when not computing, 1..ROUNDS during rounds
- last_round  out  1  high while round == ROUNDS (datapath drops MixColumns)
- busy  out  1  high in ROUND state
- out_valid  out  1  state register holds a finished ciphertext
- out_ack  in  1  consumer accepts ciphertext

## Operation
- FSM states: IDLE, ROUND, HOLD.
- IDLE:
  - ready=1, sel=0, round=0.
  - state_en = start & ~abort.
  - On accepted start, go to ROUND with round←1.
- ROUND:
  - sel=all-ones, state_en=1, busy=1.
  - If round<ROUNDS: round←round+1.
  - If round==ROUNDS: last_round=1; next state HOLD, round←0.
- HOLD:
  - out_valid=1, state_en=0 unless restarting, sel=0.
  - out_ack & ~start: go to IDLE.
  - out_ack & start: back-to-back restart. state_en=1, sel=0 this cycle; go to ROUND with round←1.
  - start without out_ack: ignored; ready=0.
- Derived outputs:
  - ready = IDLE | (HOLD & out_ack), always gated by ~abort.
  - sel bits are always all-equal. No mixed value is ever driven.
- abort:
  - Highest priority, in any state.
  - That cycle: state_en=0, ready=0.
  - Next cycle: IDLE, round=0, out_valid=0.
  - In-flight or held result is discarded.
- Round counter:
  - Never exceeds ROUNDS.
  - Never wraps; it is cleared on leaving ROUND.
- start while busy is ignored and not queued.

## Timing
- Reset values: state=IDLE, round=0, sel=0, state_en=0, last_round=0, busy=0, out_valid=0, ready=1.
- Reset mid-operation forces these values immediately, asynchronously.
- State and round are registered.
- Outputs are decoded from the registered state/round.
- Combinational exceptions: ready and state_en in IDLE/HOLD also depend on start, out_ack and abort.
- Latency (start accepted at cycle 0):
  - Cycle 0: load.
  - Cycles 1..ROUNDS: rounds, with last_round at cycle ROUNDS.
  - Cycle ROUNDS+1: out_valid rises; ciphertext is stable in the state register.
- Throughput: one block per ROUNDS+1 cycles with back-to-back restart. The minimum HOLD is one cycle.
- out_valid holds, and the state register is frozen, until out_ack or abort.

## Test plan
- Reset then idle: rst pulse mid-ROUND at round=5 → all outputs return to reset values immediately; ready=1 on the next cycle.
- Single block, ROUNDS=10: start at cycle 0 → sel=0 and state_en=1 at cycle 0. Cycles 1..10 show sel=all-ones and round=1..10, with last_round only at cycle 10. out_valid=1 from cycle 11. out_ack at cycle 13 → IDLE at cycle 14. Datapath ciphertext matches the FUTURE reference vector.
- Back-to-back: out_ack and start together at cycle 11 → load at cycle 11, round=1 at cycle 12, second out_valid at cycle 22. No idle cycle.
- Ignored starts: start held high during cycles 1..10 → no reload, round sequence unaffected. start in HOLD without out_ack → ready=0, no state_en.
- Abort: abort at round=4 → state_en=0 that cycle; IDLE with round=0 next; out_valid never asserts. Abort together with start in IDLE → no load.
- Parameter sweep ROUNDS=1 and ROUNDS=15 (CW=4) → load, then exactly ROUNDS round cycles, then HOLD. last_round is asserted for exactly one cycle per block.

Source files
------------

// File: rtl/future_round_controller.sv
// Round sequencer for the iterative 64-bit FUTURE datapath.
// Drives feedback select, state enable, round index and result handshake.
module future_round_controller #(
    parameter int ROUNDS = 10,
    parameter int CW     = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    output logic          ready,
    output logic [63:0]   sel,
    output logic          state_en,
    output logic [CW-1:0] round,
    output logic          last_round,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ack
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(ROUNDS);
    localparam logic [CW-1:0] ONE  = CW'(1);

    state_t        state;
    logic [CW-1:0] round_q;
    logic          in_idle;
    logic          in_round;
    logic          in_hold;
    logic          load;

    assign in_idle  = (state == IDLE);
    assign in_round = (state == ROUND);
    assign in_hold  = (state == HOLD);

    // A load happens when a start is accepted, from IDLE or a restarting HOLD
    assign ready    = (in_idle | (in_hold & out_ack)) & ~abort;
    assign load     = ready & start;
    assign state_en = load | (in_round & ~abort);

    // One select bit fanned out so the mux never sees a mixed operand
    assign sel        = {64{in_round}};
    assign round      = round_q;
    assign last_round = in_round & (round_q == LAST);
    assign busy       = in_round;
    assign out_valid  = in_hold;

    // Sequencer state and round counter; abort overrides every transition
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            round_q <= '0;
        end else if (abort) begin
            state   <= IDLE;
            round_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= ROUND;
                        round_q <= ONE;
                    end
                end
                ROUND: begin
                    if (round_q == LAST) begin
                        state   <= HOLD;
                        round_q <= '0;
                    end else begin
                        round_q <= round_q + ONE;
                    end
                end
                HOLD: begin
                    if (out_ack) begin
                        if (start) begin
                            state   <= ROUND;
                            round_q <= ONE;
                        end else begin
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    round_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_future_round_controller.sv
// Bench for future_round_controller: three instances (10, 1, 15 rounds)
// checked every cycle against a block-position model.
module tb_future_round_controller;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic abort;
    logic out_ack;

    logic [2:0]  rdy;
    logic [63:0] sel [3];
    logic [2:0]  en;
    logic [3:0]  rnd [3];
    logic [2:0]  last;
    logic [2:0]  bsy;
    logic [2:0]  ov;

    int checks = 0;
    int errors = 0;

    // pos: -1 idle, 1..R computing round pos, R+1 holding the result
    int pos [3];
    int rr  [3];

    // snapshots of the 10-round instance from the latest step
    logic       s_en;
    logic       s_ov;
    logic       s_last;
    logic       s_rdy;
    logic [3:0] s_rnd;

    always #5 clk = ~clk;

    future_round_controller #(.ROUNDS(10), .CW(4)) dut10 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ready(rdy[0]), .sel(sel[0]), .state_en(en[0]),
        .round(rnd[0]), .last_round(last[0]), .busy(bsy[0]),
        .out_valid(ov[0]), .out_ack(out_ack)
    );

    future_round_controller #(.ROUNDS(1), .CW(4)) dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ready(rdy[1]), .sel(sel[1]), .state_en(en[1]),
        .round(rnd[1]), .last_round(last[1]), .busy(bsy[1]),
        .out_valid(ov[1]), .out_ack(out_ack)
    );

    future_round_controller #(.ROUNDS(15), .CW(4)) dut15 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ready(rdy[2]), .sel(sel[2]), .state_en(en[2]),
        .round(rnd[2]), .last_round(last[2]), .busy(bsy[2]),
        .out_valid(ov[2]), .out_ack(out_ack)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic check_all(input int i);
        int p;
        int r;
        logic e_rdy;
        logic e_en;
        logic e_sel;
        int e_rnd;
        logic e_last;
        logic e_bsy;
        logic e_ov;
        string tag;
        p = pos[i];
        r = rr[i];
        tag = $sformatf("r%0d", r);
        if (p < 0) begin
            e_rdy = ~abort; e_en = start & ~abort; e_sel = 1'b0;
            e_rnd = 0; e_last = 1'b0; e_bsy = 1'b0; e_ov = 1'b0;
        end else if (p <= r) begin
            e_rdy = 1'b0; e_en = ~abort; e_sel = 1'b1;
            e_rnd = p; e_last = (p == r); e_bsy = 1'b1; e_ov = 1'b0;
        end else begin
            e_rdy = out_ack & ~abort;
            e_en = out_ack & start & ~abort; e_sel = 1'b0;
            e_rnd = 0; e_last = 1'b0; e_bsy = 1'b0; e_ov = 1'b1;
        end
        chk({tag, " ready"}, 64'(rdy[i]), 64'(e_rdy));
        chk({tag, " state_en"}, 64'(en[i]), 64'(e_en));
        chk({tag, " sel"}, sel[i], {64{e_sel}});
        chk({tag, " round"}, 64'(rnd[i]), 64'(e_rnd));
        chk({tag, " last_round"}, 64'(last[i]), 64'(e_last));
        chk({tag, " busy"}, 64'(bsy[i]), 64'(e_bsy));
        chk({tag, " out_valid"}, 64'(ov[i]), 64'(e_ov));
    endtask

    function automatic int next_pos(input int p, input int r);
        if (abort) return -1;
        if (p < 0) return start ? 1 : -1;
        if (p <= r) return p + 1;
        if (out_ack) return start ? 1 : -1;
        return p;
    endfunction

    // One clock: drive inputs, compare at the falling edge, advance model
    task automatic step(input logic st, input logic ab, input logic ak);
        start = st;
        abort = ab;
        out_ack = ak;
        @(negedge clk);
        for (int i = 0; i < 3; i++) check_all(i);
        s_en = en[0];
        s_ov = ov[0];
        s_last = last[0];
        s_rdy = rdy[0];
        s_rnd = rnd[0];
        for (int i = 0; i < 3; i++) pos[i] = next_pos(pos[i], rr[i]);
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        step(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        rr[0] = 10; rr[1] = 1; rr[2] = 15;
        for (int i = 0; i < 3; i++) pos[i] = -1;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        out_ack = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) check_all(i);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // single block with start held through the rounds (ignored)
        step(1'b1, 1'b0, 1'b0);
        chk("lit load en", 64'(s_en), 64'(1));
        for (int c = 1; c <= 10; c++) begin
            step(1'b1, 1'b0, 1'b0);
            if (c == 5) chk("lit round5", 64'(s_rnd), 64'(5));
            if (c == 9) chk("lit no last c9", 64'(s_last), 64'(0));
        end
        chk("lit last c10", 64'(s_last), 64'(1));
        step(1'b0, 1'b0, 1'b0);
        chk("lit valid c11", 64'(s_ov), 64'(1));
        step(1'b1, 1'b0, 1'b0);
        chk("lit hold start en", 64'(s_en), 64'(0));
        chk("lit hold ready", 64'(s_rdy), 64'(0));
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("lit idle after ack", 64'(s_ov), 64'(0));
        flush();

        // back-to-back restart
        step(1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= 10; c++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk("lit b2b load", 64'(s_en), 64'(1));
        step(1'b0, 1'b0, 1'b0);
        chk("lit b2b round1", 64'(s_rnd), 64'(1));
        for (int c = 13; c <= 21; c++) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("lit b2b valid c22", 64'(s_ov), 64'(1));
        flush();

        // abort at round 4, then abort with start in idle
        step(1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= 3; c++) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("lit abort round", 64'(s_rnd), 64'(4));
        chk("lit abort en", 64'(s_en), 64'(0));
        step(1'b0, 1'b0, 1'b0);
        chk("lit after abort", 64'(s_rnd), 64'(0));
        step(1'b1, 1'b1, 1'b0);
        chk("lit abort+start en", 64'(s_en), 64'(0));
        step(1'b0, 1'b0, 1'b0);
        chk("lit no load", 64'(s_rnd), 64'(0));

        // asynchronous reset at round 5
        step(1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= 4; c++) step(1'b0, 1'b0, 1'b0);
        chk("lit pre-reset round", 64'(rnd[0]), 64'(5));
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) pos[i] = -1;
        for (int i = 0; i < 3; i++) check_all(i);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(1'b0, 1'b0, 1'b0);
        chk("lit ready after reset", 64'(s_rdy), 64'(1));

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            step(logic'($urandom_range(0, 99) < 40),
                 logic'($urandom_range(0, 99) < 3),
                 logic'($urandom_range(0, 99) < 35));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
